// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative RV32M multiply/divide unit. Accepts the two register-file operands,
// runs a 32-iteration shift-add multiply or restoring divide, and returns the
// result word together with the destination register index. `done` feeds the
// register-file write enable, `result` feeds its write data, and `busy` stalls
// the pipeline while an operation is in flight.
//
// Handshake: `start` is a request that is only looked at while the unit is
// idle (busy=0). The edge that samples start=1 in IDLE is the accept edge E0.
// `busy` is high from just after E0 until E33. `done` is a single-cycle pulse
// in the cycle between E33 and E34, with `result`/`rd_out` valid during that
// pulse and held until the edge that raises the next `done`. Requests seen
// while busy are dropped; nothing is queued.
//
// Ports:
//   clk        system clock, rising-edge active
//   reset      asynchronous, active-high reset
//   start      operation request
//   op         RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   a, b       rs1 / rs2 operands
//   rd_in      destination register index
//   busy       operation in flight
//   done       one-cycle completion pulse
//   result     operation result
//   rd_out     destination index of the completed operation
//   state_dbg  current FSM state (0 IDLE, 1 CALC, 2 DONE)
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic [1:0]      state_dbg
);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // Latched request and working registers.
  logic [5:0]      cnt;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] opnd_q;     // multiplicand magnitude or divisor magnitude
  logic [XLEN-1:0] hi_q;       // product high half or partial remainder
  logic [XLEN-1:0] lo_q;       // multiplier / product low half, or dividend / quotient
  logic            neg_main_q; // sign of product or quotient
  logic            neg_rem_q;  // sign of remainder (follows the dividend)
  logic            div_zero_q;
  logic            div_ovf_q;

  // ---------------------------------------------------------------------------
  // Accept-time operand conditioning
  // ---------------------------------------------------------------------------
  logic            sign_a, sign_b, neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    sign_a = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    sign_b = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    neg_a  = sign_a && a[XLEN-1];
    neg_b  = sign_b && b[XLEN-1];
    mag_a  = neg_a ? -a : a;
    mag_b  = neg_b ? -b : b;
  end

  // ---------------------------------------------------------------------------
  // One iteration of either datapath
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic            div_ge;
  logic [XLEN-1:0] hi_next, lo_next;

  always_comb begin
    // Shift-add: conditionally add the multiplicand into the high half, then
    // shift {carry, hi, lo} right by one so the next multiplier bit lands in lo[0].
    mul_sum = lo_q[0] ? ({1'b0, hi_q} + {1'b0, opnd_q}) : {1'b0, hi_q};

    // Restoring divide: bring in the next dividend bit and trial-subtract.
    // The shifted remainder never exceeds 2*divisor-1, so a clear borrow bit
    // means the subtraction succeeded and its low XLEN bits hold the result.
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = ~div_diff[XLEN];

    if (op_q[2]) begin
      hi_next = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      lo_next = {lo_q[XLEN-2:0], div_ge};
    end else begin
      hi_next = mul_sum[XLEN:1];
      lo_next = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Sign fix-up and result selection (used in DONE)
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] prod_mag, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

  always_comb begin
    prod_mag = {hi_q, lo_q};
    prod_fix = neg_main_q ? -prod_mag : prod_mag;
    quo_fix  = neg_main_q ? -lo_q : lo_q;
    rem_fix  = neg_rem_q ? -hi_q : hi_q;

    fix_result = '0;
    case (op_q)
      OP_MUL:                       fix_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU: begin
        if (div_zero_q)     fix_result = '1;
        else if (div_ovf_q) fix_result = MIN_NEG;
        else                fix_result = quo_fix;
      end
      OP_REM, OP_REMU: begin
        if (div_zero_q)     fix_result = a_q;
        else if (div_ovf_q) fix_result = '0;
        else                fix_result = rem_fix;
      end
      default:              fix_result = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_CALC;
      S_CALC:  if (cnt == 6'd31) state_next = S_DONE;  // 32nd iteration this cycle
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: outputs decoded from state
  always_comb begin
    busy      = (state != S_IDLE);
    state_dbg = state;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      op_q       <= '0;
      a_q        <= '0;
      rd_q       <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      div_ovf_q  <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      rd_out     <= '0;
    end else begin
      // done is high only in the cycle after DONE, i.e. between E33 and E34.
      done <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            // Both datapaths start the same way: high half / remainder clear,
            // |a| in the low register, |b| as multiplicand or divisor.
            op_q       <= op;
            a_q        <= a;
            rd_q       <= rd_in;
            opnd_q     <= mag_b;
            hi_q       <= '0;
            lo_q       <= mag_a;
            neg_main_q <= neg_a ^ neg_b;
            neg_rem_q  <= neg_a;
            div_zero_q <= op[2] && (b == '0);
            div_ovf_q  <= op[2] && !op[0] && (a == MIN_NEG) && (b == '1);
            cnt        <= '0;
          end
        end
        S_CALC: begin
          hi_q <= hi_next;
          lo_q <= lo_next;
          cnt  <= cnt + 6'd1;
        end
        S_DONE: begin
          result <= fix_result;
          rd_out <= rd_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Directed RV32M vectors, random operations checked against a 64-bit
// arithmetic model, start-while-busy, back-to-back issue and asynchronous
// reset in mid-operation. Expected results are queued when a request is
// driven and compared when `done` pulses.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int n_pushed = 0;
  int n_done   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_rd_q[$];

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .rd_in     (rd_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out),
    .state_dbg (state_dbg)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model built on 64-bit host arithmetic.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, uy;
    logic [63:0] p;
    int          ix, iy, q;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    uy = longint'({32'b0, y});
    ix = int'(x);
    iy = int'(y);
    case (o)
      OP_MUL:    begin p = 64'(sx * sy); return p[31:0];  end
      OP_MULH:   begin p = 64'(sx * sy); return p[63:32]; end
      OP_MULHSU: begin p = 64'(sx * uy); return p[63:32]; end
      OP_MULHU:  begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      OP_DIV: begin
        if (y == 32'h0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = ix / iy;
        return 32'(q);
      end
      OP_REM: begin
        if (y == 32'h0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        q = ix % iy;
        return 32'(q);
      end
      OP_DIVU: return (y == 32'h0) ? 32'hFFFF_FFFF : x / y;
      default: return (y == 32'h0) ? x : x % y;
    endcase
  endfunction

  // Scoreboard: every done pulse consumes one queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        check("result", result, exp_q.pop_front());
        check("rd_out", {27'b0, rd_out}, exp_rd_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: issue one request, queue its expectation, and check the timing
  // window around it. If intrude >= 0, a competing DIVU 9/3 request is pulsed
  // in that cycle while the unit is busy.
  // ---------------------------------------------------------------------------
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] r, input logic [31:0] exp, input int intrude);
    int          done_at;
    int          busy_cnt;
    int          hold_err;
    logic [31:0] res0;
    logic [4:0]  rd0;
    @(negedge clk);
    op = o; a = x; b = y; rd_in = r; start = 1'b1;
    exp_q.push_back(exp);
    exp_rd_q.push_back({27'b0, r});
    n_pushed++;
    @(posedge clk);  // accept edge E0
    #1;
    start    = 1'b0;
    done_at  = -1;
    busy_cnt = 0;
    hold_err = 0;
    res0     = result;
    rd0      = rd_out;
    check("done_low_after_accept", {31'b0, done}, 32'd0);
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_at = k;
        break;
      end
      if (result !== res0 || rd_out !== rd0) hold_err++;
      if (k == intrude) begin
        op = OP_DIVU; a = 32'd9; b = 32'd3; rd_in = 5'd9; start = 1'b1;
      end
      if (k == intrude + 1) start = 1'b0;
    end
    check("latency", done_at, 32'd33);
    check("busy_cycles", busy_cnt, 32'd33);
    check("result_hold", hold_err, 32'd0);
    check("busy_at_done", {31'b0, busy}, 32'd0);
  endtask

  task automatic issue_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                             input logic [4:0] r);
    issue(o, x, y, r, model(o, x, y), -1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; rd_in = '0;
    repeat (2) @(negedge clk);
    check("reset_busy",   {31'b0, busy}, 32'd0);
    check("reset_done",   {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_rd_out", {27'b0, rd_out}, 32'd0);
    check("reset_state",  {30'b0, state_dbg}, 32'd0);
    reset = 1'b0;

    // Directed vectors with hand-derived results.
    issue(OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, -1);
    issue(OP_MULH,   32'h8000_0000,  32'h8000_0000, 5'd2,  32'h4000_0000, -1);
    issue(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, -1);
    issue(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, -1);
    issue(OP_DIV,    32'hFFFF_FFF9,  32'd2,         5'd5,  32'hFFFF_FFFD, -1);
    issue(OP_REM,    32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, -1);
    issue(OP_DIVU,   32'd100,        32'd7,         5'd7,  32'd14,        -1);
    issue(OP_REMU,   32'd100,        32'd7,         5'd8,  32'd2,         -1);
    issue(OP_DIV,    32'd5,          32'd0,         5'd10, 32'hFFFF_FFFF, -1);
    issue(OP_REMU,   32'd5,          32'd0,         5'd0,  32'd5,         -1);
    issue(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, -1);
    issue(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0,         -1);
    issue(OP_REM,    32'hFFFF_FF9C,  32'd0,         5'd13, 32'hFFFF_FF9C, -1);
    issue(OP_DIVU,   32'hDEAD_BEEF,  32'd0,         5'd14, 32'hFFFF_FFFF, -1);

    // Random operations, including divide-by-zero and small divisors.
    for (int i = 0; i < 16; i++) begin
      logic [2:0]  ro;
      logic [31:0] rx, ry;
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      case (i % 4)
        0:       ry = 32'd0;
        1:       ry = $urandom_range(1, 20);
        2:       ry = -($urandom_range(1, 20));
        default: ry = $urandom;
      endcase
      issue_model(ro, rx, ry, 5'($urandom_range(0, 31)));
    end

    // Start while busy is ignored, then a fresh request lands at E34.
    issue(OP_MUL,  32'd3, 32'd4, 5'd5, 32'd12, 10);
    issue(OP_DIVU, 32'd9, 32'd3, 5'd9, 32'd3,  -1);

    // Asynchronous reset in the middle of a DIV: no done for it afterwards.
    @(negedge clk);
    op = OP_DIV; a = 32'hFFFF_FF9C; b = 32'd7; rd_in = 5'd17; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy",   {31'b0, busy}, 32'd0);
    check("abort_done",   {31'b0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_rd_out", {27'b0, rd_out}, 32'd0);
    check("abort_state",  {30'b0, state_dbg}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("no_done_after_abort", n_done, n_pushed);
    check("idle_after_abort", {31'b0, busy}, 32'd0);

    issue(OP_MUL, 32'd6, 32'd7, 5'd3, 32'd42, -1);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 32'd0);
    check("done_count", n_done, n_pushed);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
